// File: rtl/vector_pkg.sv
// Shared types and index-width helpers for the wave scheduler.
package vector_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_SPAWN    = 3'd2,
    S_WAVE_END = 3'd3,
    S_OVER     = 3'd4
  } sched_state_t;

  localparam int DEF_N_ENEMY = 4;
  localparam int DEF_N_BASE  = 4;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int SLOT_W = idx_w(DEF_N_ENEMY);
  localparam int BASE_W = idx_w(DEF_N_BASE);

endpackage

// File: rtl/rr_pick.sv
// Cyclic picker: first set request bit strictly after `last`, wrapping around.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int W = $clog2(N);

  always_comb begin
    int c;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    // k = N revisits `last` itself, so a lone remaining request is still found
    for (int k = 1; k <= N; k++) begin
      c = int'(last) + k;
      if (c >= N) c = c - N;
      if (!valid && req[c]) begin
        idx   = W'(c);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wave_scheduler.sv
// Enemy wave sequencer: spawns into free slots on a frame-tick interval and
// targets un-nuked bases round-robin; declares game over when all bases fall.
module wave_scheduler
  import vector_pkg::*;
#(
  parameter int N_ENEMY        = DEF_N_ENEMY,
  parameter int N_BASE         = DEF_N_BASE,
  parameter int WAVE_SIZE      = 8,
  parameter int SPAWN_INTERVAL = 60
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic                      start,
  input  logic [N_ENEMY-1:0]        enemy_done,
  input  logic [N_BASE-1:0]         base_nuked,
  output logic [N_ENEMY-1:0]        spawn,
  output logic [$clog2(N_BASE)-1:0] spawn_base,
  output logic [N_ENEMY-1:0]        slot_busy,
  output logic [3:0]                wave_num,
  output logic                      game_over,
  output sched_state_t              dbg_state
);

  localparam int BW = $clog2(N_BASE);

  sched_state_t   state, state_nx;
  logic [9:0]     interval_cnt;
  logic [7:0]     spawned_cnt;
  logic [BW-1:0]  last_base;

  logic [N_ENEMY-1:0] free_oh;
  logic [BW-1:0]      pick_base;
  logic               pick_valid;
  logic               all_nuked, wave_done, can_spawn;
  logic               do_spawn, do_wave_end, cnt_inc;

  assign dbg_state = state;

  // lowest-index free slot, one-hot; descending loop lets the lowest win
  always_comb begin
    free_oh = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
  end

  rr_pick #(.N(N_BASE)) u_base_pick (
    .req   (~base_nuked),
    .last  (last_base),
    .idx   (pick_base),
    .valid (pick_valid)
  );

  assign all_nuked = &base_nuked;
  assign wave_done = (spawned_cnt == 8'(WAVE_SIZE)) && (slot_busy == '0);
  assign can_spawn = (spawned_cnt < 8'(WAVE_SIZE)) && (|free_oh) && pick_valid;

  // next state; all-nuked beats wave end, which beats a pending spawn
  always_comb begin
    state_nx    = state;
    do_spawn    = 1'b0;
    do_wave_end = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_WAIT;
      S_WAIT: begin
        if (all_nuked) begin
          state_nx = S_OVER;
        end else if (wave_done) begin
          state_nx = S_WAVE_END;
        end else if (frame_tick) begin
          if (interval_cnt == 10'(SPAWN_INTERVAL - 1)) begin
            if (can_spawn) begin
              do_spawn = 1'b1;
              state_nx = S_SPAWN;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_SPAWN: state_nx = all_nuked ? S_OVER : S_WAIT;
      S_WAVE_END: begin
        if (all_nuked) begin
          state_nx = S_OVER;
        end else begin
          do_wave_end = 1'b1;
          state_nx    = S_WAIT;
        end
      end
      S_OVER: state_nx = S_OVER;
      default: state_nx = S_IDLE;
    endcase
  end

  // spawn outputs are loaded on the deciding edge so they are visible in SPAWN
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      interval_cnt <= '0;
      spawned_cnt  <= '0;
      last_base    <= BW'(N_BASE - 1);
      spawn        <= '0;
      spawn_base   <= '0;
      slot_busy    <= '0;
      wave_num     <= '0;
      game_over    <= 1'b0;
    end else begin
      state     <= state_nx;
      spawn     <= do_spawn ? free_oh : '0;
      slot_busy <= (slot_busy & ~enemy_done) | (do_spawn ? free_oh : '0);
      if (do_spawn) begin
        spawn_base   <= pick_base;
        last_base    <= pick_base;
        spawned_cnt  <= spawned_cnt + 8'd1;
        interval_cnt <= '0;
      end else if (cnt_inc) begin
        interval_cnt <= interval_cnt + 10'd1;
      end
      if (do_wave_end) begin
        if (wave_num != 4'hf) wave_num <= wave_num + 4'd1;
        spawned_cnt  <= '0;
        interval_cnt <= '0;
      end
      if (state_nx == S_OVER) game_over <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wave_scheduler.sv
// Directed bench for wave_scheduler: spawn order, base skipping, slot blocking,
// wave rollover, game over priority and mid-wave reset.
module tb_wave_scheduler;
  import vector_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [3:0] enemy_done = '0;
  logic [3:0] enemy_done2 = '0;
  logic [3:0] base_nuked = '0;

  logic [3:0]   spawn, slot_busy, wave_num;
  logic [1:0]   spawn_base;
  logic         game_over;
  sched_state_t dbg_state;

  logic [3:0]   spawn2, slot_busy2, wave_num2;
  logic [1:0]   spawn_base2;
  logic         game_over2;
  sched_state_t dbg_state2;

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  wave_scheduler #(.N_ENEMY(4), .N_BASE(4), .WAVE_SIZE(8), .SPAWN_INTERVAL(2)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .enemy_done(enemy_done), .base_nuked(base_nuked),
    .spawn(spawn), .spawn_base(spawn_base), .slot_busy(slot_busy),
    .wave_num(wave_num), .game_over(game_over), .dbg_state(dbg_state)
  );

  wave_scheduler #(.N_ENEMY(4), .N_BASE(4), .WAVE_SIZE(2), .SPAWN_INTERVAL(2)) dut2 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .enemy_done(enemy_done2), .base_nuked(base_nuked),
    .spawn(spawn2), .spawn_base(spawn_base2), .slot_busy(slot_busy2),
    .wave_num(wave_num2), .game_over(game_over2), .dbg_state(dbg_state2)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] m);
    enemy_done = m;
    step();
    enemy_done = '0;
  endtask

  task automatic spawn_pair(input string tag, input logic [3:0] exp_slot, input logic [1:0] exp_base);
    pulse_tick();
    pulse_tick();
    check({tag, "_spawn"}, 32'(spawn), 32'(exp_slot));
    check({tag, "_base"}, 32'(spawn_base), 32'(exp_base));
    step();
  endtask

  initial begin
    step();
    step();
    check("rst_spawn", 32'(spawn), 32'h0);
    check("rst_busy", 32'(slot_busy), 32'h0);
    check("rst_wave", 32'(wave_num), 32'h0);
    check("rst_over", 32'(game_over), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // run A: first two spawns target bases 0 then 1
    rst = 1'b0;
    start = 1'b1;
    step();
    check("a_state_wait", 32'(dbg_state), 32'(S_WAIT));
    pulse_tick();
    check("a_tick1_nospawn", 32'(spawn), 32'h0);
    pulse_tick();
    check("a_s0_spawn", 32'(spawn), 32'h1);
    check("a_s0_base", 32'(spawn_base), 32'h0);
    check("a_s0_busy", 32'(slot_busy), 32'h1);
    check("a_s0_spawn2", 32'(spawn2), 32'h1);
    step();
    check("a_spawn_pulse_end", 32'(spawn), 32'h0);
    pulse_tick();
    pulse_tick();
    check("a_s1_spawn", 32'(spawn), 32'h2);
    check("a_s1_base", 32'(spawn_base), 32'h1);
    check("a_s1_spawn2", 32'(spawn2), 32'h2);
    step();

    // WAVE_SIZE=2 instance: free both slots, wave rolls over
    enemy_done2 = 4'b0011;
    step();
    enemy_done2 = '0;
    check("w_busy_clear", 32'(slot_busy2), 32'h0);
    step();
    check("w_state_end", 32'(dbg_state2), 32'(S_WAVE_END));
    step();
    check("w_wave_num", 32'(wave_num2), 32'h1);
    check("w_state_wait", 32'(dbg_state2), 32'(S_WAIT));
    pulse_tick();
    pulse_tick();
    check("w_respawn", 32'(spawn2), 32'h1);
    check("w_respawn_base", 32'(spawn_base2), 32'h2);
    check("a_s2_spawn", 32'(spawn), 32'h4);
    check("a_s2_base", 32'(spawn_base), 32'h2);
    step();

    // mid-wave reset discards everything
    rst = 1'b1;
    step();
    check("mrst_spawn", 32'(spawn), 32'h0);
    check("mrst_busy", 32'(slot_busy), 32'h0);
    check("mrst_base", 32'(spawn_base), 32'h0);
    check("mrst_wave2", 32'(wave_num2), 32'h0);
    check("mrst_state", 32'(dbg_state), 32'(S_IDLE));

    // run B: base 1 nuked after first spawn
    rst = 1'b0;
    step();
    spawn_pair("b0", 4'b0001, 2'd0);
    base_nuked = 4'b0010;
    spawn_pair("b1", 4'b0010, 2'd2);
    spawn_pair("b2", 4'b0100, 2'd3);
    spawn_pair("b3", 4'b1000, 2'd0);
    check("b_all_busy", 32'(slot_busy), 32'hf);

    // all slots busy: interval holds, nothing spawns
    pulse_tick();
    pulse_tick();
    check("blk_spawn_a", 32'(spawn), 32'h0);
    pulse_tick();
    check("blk_spawn_b", 32'(spawn), 32'h0);
    pulse_done(4'b0100);
    check("blk_freed", 32'(slot_busy), 32'hb);
    pulse_tick();
    check("blk_release_spawn", 32'(spawn), 32'h4);
    check("blk_release_base", 32'(spawn_base), 32'h2);
    step();

    // all bases nuked together with a pending spawn
    pulse_done(4'b0001);
    pulse_tick();
    check("ov_pre_nospawn", 32'(spawn), 32'h0);
    base_nuked = 4'b1111;
    pulse_tick();
    check("ov_spawn", 32'(spawn), 32'h0);
    check("ov_game_over", 32'(game_over), 32'h1);
    check("ov_state", 32'(dbg_state), 32'(S_OVER));
    pulse_done(4'b1000);
    check("ov_busy_track", 32'(slot_busy), 32'h6);
    pulse_tick();
    pulse_tick();
    check("ov_hold_spawn", 32'(spawn), 32'h0);
    check("ov_hold_over", 32'(game_over), 32'h1);
    rst = 1'b1;
    step();
    check("ov_rst_over", 32'(game_over), 32'h0);
    check("ov_rst_state", 32'(dbg_state), 32'(S_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wave_scheduler.md
# wave_scheduler

Sequences enemy waves for the game. Owns a pool of enemy slots, spawns enemies into free slots at a fixed frame interval, and assigns each spawned enemy a target base in round-robin order, skipping nuked bases. Consumes the per-base `base_nuked` flags from the base control instances. Declares game over once every base is nuked. Sits between the frame timing logic and the enemy movement/base control units.

## Interface
- `N_ENEMY`, 4: number of enemy slots (2..8).
- `N_BASE`, 4: number of bases (2..8).
- `WAVE_SIZE`, 8: enemies spawned per wave (1..255).
- `SPAWN_INTERVAL`, 60: frame ticks between spawns (1..1023).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `start` in 1: level-sensitive; begins wave 0 from IDLE.
- `enemy_done` in N_ENEMY: pulse per slot; the enemy was destroyed or reached its base, and the slot is freed.
- `base_nuked` in N_BASE: sticky per-base nuked flags.
- `spawn` out N_ENEMY: one-hot, one-cycle spawn pulse for the chosen slot.
- `spawn_base` out $clog2(N_BASE): target base index; valid while `spawn` is non-zero, otherwise held.
- `slot_busy` out N_ENEMY: registered occupancy mask.
- `wave_num` out 4: current wave; saturates at 15.
- `game_over` out 1: sticky until `rst`.

## Operation
- States: IDLE, WAIT, SPAWN, WAVE_END, OVER.
- IDLE: all outputs 0, counters cleared. `start`=1 moves to WAIT.
- WAIT:
  - `interval_cnt` increments on each `frame_tick`.
  - When `interval_cnt` == SPAWN_INTERVAL-1 on a `frame_tick`, the spawn condition is evaluated: `spawned_cnt` < WAVE_SIZE, a free slot exists, and an un-nuked base exists.
  - If the condition holds, move to SPAWN.
  - If it fails, `interval_cnt` holds at SPAWN_INTERVAL-1 and the spawn fires on the first `frame_tick` at which the condition holds.
- SPAWN (exactly 1 cycle):
  - `spawn` pulses the lowest-index free slot and sets that slot's `slot_busy` bit.
  - `spawn_base` is the first un-nuked base strictly after `last_base`, searching cyclically. After reset `last_base` = N_BASE-1, so the first target is base 0.
  - `last_base` is then updated to `spawn_base`.
  - `spawned_cnt` increments, `interval_cnt` clears, and the state returns to WAIT.
- WAVE_END entry: from WAIT when `spawned_cnt` == WAVE_SIZE and `slot_busy` == 0.
- WAVE_END (1 cycle): `wave_num` increments (saturating), `spawned_cnt` and `interval_cnt` clear, then the state returns to WAIT.
- OVER:
  - Entered from WAIT, SPAWN or WAVE_END when `base_nuked` is all ones.
  - This check has priority over every other transition, including a pending spawn.
  - `game_over`=1. `spawn` stays 0 and `slot_busy` keeps tracking `enemy_done`.
  - The state persists until `rst`.
- `slot_busy[i]`: cleared by `enemy_done[i]`.
  - `enemy_done` on an already-free slot is ignored.
  - A same-cycle set and clear on one slot cannot occur, because spawn selects only free slots. If it did occur, the set wins.

## Timing
- All outputs are registered. Every output resets to 0 on the clock edge with `rst`=1, regardless of state. A reset mid-wave discards all slots and counters.
- Spawn latency: `spawn` is asserted in the cycle after the qualifying `frame_tick` is sampled.
- `enemy_done` in cycle t: the slot is free in `slot_busy` at t+1 and is eligible for the spawn decision made at t+1.
- A `base_nuked` change at cycle t affects the target choice at t+1. `game_over` rises at t+1 after the last base is nuked.
- Widths:
  - `interval_cnt`: 10 bits.
  - `spawned_cnt`: 8 bits.
  - Slot and base searches are combinational priority encoders.

## Structure
- Put the `sched_state_t` enum and the slot/base index width constants in `vector_pkg`.
- Use one sub-module, `rr_pick` (parameter N): given a request mask and a last index, it returns the next cyclic index plus a valid flag. It is used for base selection.
- Lowest-free-slot selection is inline.

## Test plan
- Reset with SPAWN_INTERVAL=2 and `start`=1: the 2nd `frame_tick` gives `spawn`=0001 and `spawn_base`=0. The next spawn gives `spawn`=0010 and `spawn_base`=1.
- Nuke base 1 before the second spawn: `spawn_base` sequence 0, 2, 3, 0.
- All 4 slots busy with interval elapsed: no spawn. `enemy_done`=0100 gives `spawn`=0100 on the next `frame_tick`.
- WAVE_SIZE=2, two spawns then both `enemy_done`: `wave_num` becomes 1 and `spawned_cnt` restarts at 0.
- `base_nuked`=1111 in the same cycle as a pending spawn: no `spawn`, `game_over`=1 next cycle, held until `rst`.
- `rst` asserted mid-wave with slots busy: all outputs 0 next cycle and the state is IDLE.
